add32_sum_fifo: RTL
===================

// Module: add32_sum_fifo
// PURPOSE
//  Downstream capture stage for the clocked 32-bit adder. It buffers each qualified sum word in a
//  small synchronous FIFO and presents the words to the consumer over a valid/ready handshake.
//  It also counts words dropped on overflow. The adder has no back-pressure, so this block
//  absorbs consumer stalls and reports loss rather than stalling the adder.
// PARAMETERS
//  WIDTH   32  data width of a sum word
//  DEPTH   8   FIFO entries; power of two, >= 2
//  AW      3   pointer width = log2(DEPTH); derived, not overridden
//  DCW     8   width of the saturating drop counter
// PORTS
//  clk        in   1      single clock, all state rising-edge
//  rst        in   1      synchronous, active-high reset
//  sum_valid  in   1      sum word on sum_in is to be captured this cycle
//  sum_in     in   WIDTH  sum word from the adder output
//  out_valid  out  1      FIFO head word available
//  out_data   out  WIDTH  FIFO head word (show-ahead)
//  out_ready  in   1      consumer accepts head this cycle
//  count      out  AW+1   occupancy, 0..DEPTH
//  full       out  1      count == DEPTH
//  empty      out  1      count == 0
//  overflow   out  1      sticky; set when a word is dropped
//  drop_cnt   out  DCW    dropped words; saturates at 2^DCW-1
//  clr_ovf    in   1      synchronous clear of overflow and drop_cnt
// BEHAVIOUR
//  - Reset (rst=1 at posedge): rd_ptr=wr_ptr=0, count=0, empty=1, full=0, out_valid=0,
//    overflow=0, drop_cnt=0. out_data is don't-care while out_valid=0. Memory is not cleared.
//  - pop = out_valid & out_ready. push = sum_valid & (~full | pop).
//  - Full FIFO with simultaneous push and pop: both take effect; count is unchanged.
//  - Empty FIFO: pop is impossible because out_valid=0. No same-cycle bypass.
//  - Latency: a word pushed at edge N appears on out_data with out_valid=1 after edge N
//    (one cycle).
//  - out_data = mem[rd_ptr], read combinationally; out_valid = ~empty. Both are stable until pop.
//  - Pointers are AW bits wide and wrap modulo DEPTH.
//  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - Drop condition: sum_valid & full & ~pop. The word is discarded, overflow<=1, and drop_cnt
//    increments, holding at its maximum value.
//  - clr_ovf=1: overflow<=0 and drop_cnt<=0. If a drop occurs in the same cycle, clr_ovf wins
//    and the drop is not counted.
//  - rst mid-operation discards all contents on that edge. rst takes priority over every other
//    input.
//  - Word order is strict FIFO; no reordering and no duplication.
// CONFIGURATION
//  ADD32_SUM_CHK_EN defined:
//   - Adds output port chk_sum [WIDTH-1:0].
//   - chk_sum is the running modulo-2^WIDTH sum of every pushed word (dropped words excluded).
//   - Reset to 0 by rst; not affected by clr_ovf. Updated on the edge of the push.
//  ADD32_SUM_CHK_EN undefined:
//   - Port and accumulator are absent.
//   - All other behaviour is identical.
// STRUCTURE
//  - Shared package add32_pkg: WIDTH default (32), DCW default (8), and typedef sum_word_t
//    (logic [WIDTH-1:0]).
//  - Sub-module sum_fifo_mem: DEPTH x WIDTH register array with one synchronous write port
//    (we, waddr, wdata) and one combinational read port (raddr -> rdata).
//  - Pointer/count control, handshake, overflow logic and the optional checksum stay in
//    add32_sum_fifo.
// TESTING
//  1. Reset then idle: after rst, count=0, empty=1, out_valid=0, overflow=0, drop_cnt=0.
//  2. Single word: push 0x0000_0005 with out_ready=0. Next cycle out_valid=1,
//     out_data=0x0000_0005, count=1. Set out_ready=1 -> empty=1 one cycle later.
//  3. Fill and wrap: push 0x10..0x17 with out_ready=0 -> full=1, count=8. Push 0xAA ->
//     dropped, overflow=1, drop_cnt=1. Drain -> 0x10..0x17 in order. Refill across the wrap
//     -> order preserved.
//  4. Full + simultaneous push/pop: at count=8, sum_valid=1 and out_ready=1 -> count stays 8,
//     no drop, new word is last out.
//  5. Drop counter: 300 pushes while full, no pop -> drop_cnt=255 (saturated). clr_ovf=1
//     together with a drop -> overflow=0, drop_cnt=0.
//  6. Reset mid-stream at count=5 -> empty=1 next cycle. With ADD32_SUM_CHK_EN: push
//     0xFFFF_FFFF then 0x0000_0002 -> chk_sum=0x0000_0001.

Source files
------------

// File: rtl/add32_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | add32_pkg : shared word width, drop-counter width and sum word type    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package add32_pkg;
  localparam int WIDTH = 32;
  localparam int DCW   = 8;

  typedef logic [WIDTH-1:0] sum_word_t;
endpackage
`default_nettype wire

// File: rtl/add32_sum_fifo_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | add32_sum_fifo_if : capture-side, consumer-side and status signals     |
// | Rev 1.0   (chk_sum present when ADD32_SUM_CHK_EN is defined)           |
// +-----------------------------------------------------------------------+
interface add32_sum_fifo_if
  import add32_pkg::*;
#(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic            sum_valid;
  sum_word_t       sum_in;
  logic            out_valid;
  sum_word_t       out_data;
  logic            out_ready;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  logic            overflow;
  logic [DCW-1:0]  drop_cnt;
  logic            clr_ovf;
`ifdef ADD32_SUM_CHK_EN
  sum_word_t       chk_sum;
`endif

  modport master (
    output sum_valid, sum_in, out_ready, clr_ovf,
    input  out_valid, out_data, count, full, empty, overflow, drop_cnt
`ifdef ADD32_SUM_CHK_EN
    , chk_sum
`endif
  );

  modport slave (
    input  sum_valid, sum_in, out_ready, clr_ovf,
    output out_valid, out_data, count, full, empty, overflow, drop_cnt
`ifdef ADD32_SUM_CHK_EN
    , chk_sum
`endif
  );
endinterface
`default_nettype wire

// File: rtl/sum_fifo_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sum_fifo_mem : DEPTH x WIDTH array, sync write, combinational read     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module sum_fifo_mem
  import add32_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  sum_word_t     wdata_i,
  input  logic [AW-1:0] raddr_i,
  output sum_word_t     rdata_o
);
  sum_word_t mem_q [DEPTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule
`default_nettype wire

// File: rtl/add32_sum_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | add32_sum_fifo : show-ahead sum FIFO with drop counting; optional      |
// | running checksum under ADD32_SUM_CHK_EN.  Rev 1.0                      |
// +-----------------------------------------------------------------------+
module add32_sum_fifo
  import add32_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  add32_sum_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           overflow_q, overflow_d;
  logic [DCW-1:0] drop_cnt_q, drop_cnt_d;
  logic           full, empty, pop, push, drop;
  sum_word_t      rdata;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign pop   = ~empty & bus.out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push  = bus.sum_valid & (~full | pop);
  assign drop  = bus.sum_valid & full & ~pop;

  sum_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.sum_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
    // Clear beats a same-cycle drop, so that drop goes uncounted.
    if (bus.clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.out_valid = ~empty;
  assign bus.out_data  = rdata;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;

`ifdef ADD32_SUM_CHK_EN
  sum_word_t chk_q, chk_d;

  assign chk_d = push ? (chk_q + bus.sum_in) : chk_q;

  always_ff @(posedge clk) begin
    if (rst) chk_q <= '0;
    else     chk_q <= chk_d;
  end

  assign bus.chk_sum = chk_q;
`endif
endmodule
`default_nettype wire
